// File: rtl/ram64_pkg.sv
// ram64_pkg: shared constants and state encoding for the RAM64 block copier.
//   RAM_AW    - RAM64 word address width (64 words)
//   RAM_DW    - RAM64 data word width
//   LEN_W     - width of the word-count request field
//   MAX_WORDS - largest copy length; longer requests are clamped to it
// Build option: RAM64_COPIER_VERIFY_EN adds the S_VFY read-back state.
package ram64_pkg;

  localparam int unsigned RAM_AW    = 6;
  localparam int unsigned RAM_DW    = 16;
  localparam int unsigned LEN_W     = 7;
  localparam int unsigned MAX_WORDS = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
`ifdef RAM64_COPIER_VERIFY_EN
    S_VFY,
`endif
    S_DONE
  } state_t;

endpackage

// File: rtl/ram64_copier_if.sv
// ram64_copier_if: request handshake plus RAM64 port of the copier.
//   start/src/dst/len : copy request (environment -> copier)
//   busy/done         : status (copier -> environment)
//   mem_e/mem_w/mem_r/mem_adr/mem_din : RAM64 controls (copier -> RAM)
//   mem_dout          : RAM64 read data (RAM -> copier)
//   err               : sticky verify mismatch (RAM64_COPIER_VERIFY_EN only)
// Modports: master = copier side, slave = requester/RAM side.
interface ram64_copier_if
  import ram64_pkg::*;
#(
  parameter int unsigned AW = RAM_AW,
  parameter int unsigned DW = RAM_DW
);

  logic             start;
  logic [AW-1:0]    src;
  logic [AW-1:0]    dst;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             mem_e;
  logic             mem_w;
  logic             mem_r;
  logic [AW-1:0]    mem_adr;
  logic [DW-1:0]    mem_din;
  logic [DW-1:0]    mem_dout;
`ifdef RAM64_COPIER_VERIFY_EN
  logic             err;

  modport master (
    input  start, src, dst, len, mem_dout,
    output busy, done, mem_e, mem_w, mem_r, mem_adr, mem_din, err
  );

  modport slave (
    output start, src, dst, len, mem_dout,
    input  busy, done, mem_e, mem_w, mem_r, mem_adr, mem_din, err
  );
`else
  modport master (
    input  start, src, dst, len, mem_dout,
    output busy, done, mem_e, mem_w, mem_r, mem_adr, mem_din
  );

  modport slave (
    output start, src, dst, len, mem_dout,
    input  busy, done, mem_e, mem_w, mem_r, mem_adr, mem_din
  );
`endif

endinterface

// File: rtl/ram64_copier_addr_gen.sv
// addr_gen: base + index word address, wrapping modulo 2**AW (64 words).
//   i_base - first word address of the region
//   i_idx  - word index within the copy
//   o_adr  - wrapped word address
module addr_gen
  import ram64_pkg::*;
#(
  parameter int unsigned AW = RAM_AW
) (
  input  logic [AW-1:0] i_base,
  input  logic [AW-1:0] i_idx,
  output logic [AW-1:0] o_adr
);

  // Natural AW-bit overflow provides the wrap.
  assign o_adr = i_base + i_idx;

endmodule

// File: rtl/ram64_copier.sv
// ram64_copier: copies len words from src to dst in a RAM64, one word per
// RD/WR pair in strictly ascending order (overlaps replicate forward).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ram64_copier_if master modport (request, status, RAM64 port)
// Build option: RAM64_COPIER_VERIFY_EN adds a VFY read-back after every
// write and a sticky err flag, cleared by reset or the next accepted start.
// All outputs are registered; RAM addresses for the next state are formed
// one cycle ahead by the two addr_gen instances.
module ram64_copier
  import ram64_pkg::*;
#(
  parameter int unsigned AW = RAM_AW,
  parameter int unsigned DW = RAM_DW
) (
  input  logic           clk,
  input  logic           rst,
  ram64_copier_if.master bus
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

  state_t           r_state;
  logic [AW-1:0]    r_src;
  logic [AW-1:0]    r_dst;
  logic [AW-1:0]    r_i;
  logic [LEN_W-1:0] r_len;
  logic [DW-1:0]    r_buf;
  logic             r_busy;
  logic             r_done;
  logic             r_mem_e;
  logic             r_mem_w;
  logic             r_mem_r;
  logic [AW-1:0]    r_mem_adr;
`ifdef RAM64_COPIER_VERIFY_EN
  logic             r_err;
`endif

  logic [LEN_W-1:0] w_len_eff;
  logic [AW-1:0]    w_src_base;
  logic [AW-1:0]    w_src_idx;
  logic [AW-1:0]    w_src_adr;
  logic [AW-1:0]    w_dst_adr;
  logic             w_last;
  logic             w_adv;

  // Requests above 64 words are clamped.
  assign w_len_eff = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;

  // Source address for the upcoming RD: word 0 of the new request while
  // idle, otherwise the word after the current one.
  assign w_src_base = (r_state == S_IDLE) ? bus.src : r_src;
  assign w_src_idx  = (r_state == S_IDLE) ? '0 : (r_i + AW'(1));
  assign w_last     = (LEN_W'(r_i) == (r_len - LEN_W'(1)));

`ifdef RAM64_COPIER_VERIFY_EN
  assign w_adv = (r_state == S_VFY);
`else
  assign w_adv = (r_state == S_WR);
`endif

  addr_gen #(.AW(AW)) u_src_gen (
    .i_base (w_src_base),
    .i_idx  (w_src_idx),
    .o_adr  (w_src_adr)
  );

  addr_gen #(.AW(AW)) u_dst_gen (
    .i_base (r_dst),
    .i_idx  (r_i),
    .o_adr  (w_dst_adr)
  );

  // Copy FSM with registered outputs loaded for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_i       <= '0;
      r_len     <= '0;
      r_buf     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_mem_e   <= 1'b0;
      r_mem_w   <= 1'b0;
      r_mem_r   <= 1'b0;
      r_mem_adr <= '0;
`ifdef RAM64_COPIER_VERIFY_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
`ifdef RAM64_COPIER_VERIFY_EN
            r_err <= 1'b0;
`endif
            r_busy <= 1'b1;
            if (w_len_eff != '0) begin
              r_src     <= bus.src;
              r_dst     <= bus.dst;
              r_len     <= w_len_eff;
              r_i       <= '0;
              r_mem_e   <= 1'b1;
              r_mem_r   <= 1'b1;
              r_mem_adr <= w_src_adr;
              r_state   <= S_RD;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_RD: begin
          r_buf     <= bus.mem_dout;
          r_mem_r   <= 1'b0;
          r_mem_w   <= 1'b1;
          r_mem_adr <= w_dst_adr;
          r_state   <= S_WR;
        end
        S_WR: begin
`ifdef RAM64_COPIER_VERIFY_EN
          // Read back the word just written; address is unchanged.
          r_mem_w <= 1'b0;
          r_mem_r <= 1'b1;
          r_state <= S_VFY;
`endif
        end
`ifdef RAM64_COPIER_VERIFY_EN
        S_VFY: begin
          if (bus.mem_dout != r_buf) begin
            r_err <= 1'b1;
          end
        end
`endif
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Advance step shared by WR (plain build) and VFY (verify build).
      if (w_adv) begin
        if (w_last) begin
          r_mem_e   <= 1'b0;
          r_mem_w   <= 1'b0;
          r_mem_r   <= 1'b0;
          r_mem_adr <= '0;
          r_buf     <= '0;
          r_done    <= 1'b1;
          r_state   <= S_DONE;
        end else begin
          r_i       <= r_i + AW'(1);
          r_mem_e   <= 1'b1;
          r_mem_w   <= 1'b0;
          r_mem_r   <= 1'b1;
          r_mem_adr <= w_src_adr;
          r_state   <= S_RD;
        end
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.mem_e   = r_mem_e;
  assign bus.mem_w   = r_mem_w;
  assign bus.mem_r   = r_mem_r;
  assign bus.mem_adr = r_mem_adr;
  assign bus.mem_din = r_buf;
`ifdef RAM64_COPIER_VERIFY_EN
  assign bus.err     = r_err;
`endif

endmodule

// File: tb/tb_ram64_copier.sv
// tb_ram64_copier: self-checking bench for ram64_copier with a RAM64 model,
// a write scoreboard and a table of copy requests.
module tb_ram64_copier;
  import ram64_pkg::*;

`ifdef RAM64_COPIER_VERIFY_EN
  localparam int K = 3;
`else
  localparam int K = 2;
`endif

  typedef struct packed {
    logic [5:0]  adr;
    logic [15:0] dat;
  } wr_exp_t;

  typedef struct {
    logic [5:0]       src;
    logic [5:0]       dst;
    logic [6:0]       len;
    int               eff;
    int               nexp;
    logic [2:0][15:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram64_copier_if #(.AW(RAM_AW), .DW(RAM_DW)) bus ();

  ram64_copier dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM64 model with a preload port and an optional corrupting write.
  logic [15:0] ram [64];
  logic [15:0] model [64];
  logic        pl_we;
  logic [5:0]  pl_adr;
  logic [15:0] pl_dat;
  logic        corrupt_en;
  logic [5:0]  corrupt_adr;

  assign bus.mem_dout = (bus.mem_e && bus.mem_r) ? ram[bus.mem_adr] : 16'h0000;

  always @(posedge clk) begin
    if (pl_we)
      ram[pl_adr] <= pl_dat;
    else if (bus.mem_e && bus.mem_w)
      ram[bus.mem_adr] <= (corrupt_en && bus.mem_adr == corrupt_adr) ? (bus.mem_din ^ 16'h00FF) : bus.mem_din;
  end

  int n_checks = 0;
  int n_fail = 0;
  int n_conflict = 0;
  int n_e = 0;
  wr_exp_t sb[$];
  wr_exp_t sb_e;
  logic err_at_done;
  logic err_at_c1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: pops the scoreboard on every write cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_w && bus.mem_r) n_conflict++;
      if (bus.mem_e) n_e++;
      if (bus.mem_e && bus.mem_w) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_write", 32'(bus.mem_adr), 32'hFFFF_FFFF);
        end else begin
          sb_e = sb.pop_front();
          chk("wr_adr", 32'(bus.mem_adr), 32'(sb_e.adr));
          chk("wr_dat", 32'(bus.mem_din), 32'(sb_e.dat));
        end
      end
    end
  end

  function automatic logic [31:0] out_bits();
`ifdef RAM64_COPIER_VERIFY_EN
    return 32'({bus.err, bus.busy, bus.done, bus.mem_e, bus.mem_w, bus.mem_r, bus.mem_adr, bus.mem_din});
`else
    return 32'({bus.busy, bus.done, bus.mem_e, bus.mem_w, bus.mem_r, bus.mem_adr, bus.mem_din});
`endif
  endfunction

  task automatic preload(input logic [5:0] a, input logic [15:0] v);
    pl_we  = 1'b1;
    pl_adr = a;
    pl_dat = v;
    model[a] = v;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic chk_mem(input logic [5:0] d, input int eff);
    logic [5:0] a;
    for (int k = 0; k < eff; k++) begin
      a = 6'(32'(d) + k);
      chk("mem_word", 32'(ram[a]), 32'(model[a]));
    end
  endtask

  // Issue one copy from a negedge; returns at the negedge after DONE.
  task automatic run_copy(input logic [5:0] s, input logic [5:0] d, input logic [6:0] l,
                          input int eff, input bit exp_err);
    logic [5:0] as, ad;
    int cyc;
    bit busy_all;
    for (int k = 0; k < eff; k++) begin
      as = 6'(32'(s) + k);
      ad = 6'(32'(d) + k);
      sb.push_back('{adr: ad, dat: model[as]});
      model[ad] = model[as];
    end
    bus.start = 1'b1;
    bus.src   = s;
    bus.dst   = d;
    bus.len   = l;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    busy_all = 1'b1;
    // Request fields and start are ignored once the copy is running.
    bus.src = 6'($urandom);
    bus.dst = 6'($urandom);
    bus.len = 7'($urandom);
`ifdef RAM64_COPIER_VERIFY_EN
    err_at_c1 = bus.err;
    chk("err_cleared_on_start", 32'(err_at_c1), 32'd0);
`endif
    while (bus.done !== 1'b1 && cyc < 300) begin
      if (bus.busy !== 1'b1) busy_all = 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk("latency", 32'(cyc), 32'(K * eff + 1));
    chk("busy_before_done", 32'(busy_all), 32'd1);
    chk("busy_at_done", 32'(bus.busy), 32'd1);
    chk("mem_idle_at_done", 32'({bus.mem_e, bus.mem_w, bus.mem_r, bus.mem_adr, bus.mem_din}), 32'd0);
`ifdef RAM64_COPIER_VERIFY_EN
    err_at_done = bus.err;
    chk("err_at_done", 32'(err_at_done), 32'(exp_err));
`else
    if (exp_err) chk("err_unsupported", 32'd1, 32'd0);
`endif
    @(negedge clk);
    chk("done_one_cycle", 32'({bus.done, bus.busy}), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  vec_t tbl[6];

  initial begin
    int e_before;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.src = '0;
    bus.dst = '0;
    bus.len = '0;
    pl_we = 1'b0;
    pl_adr = '0;
    pl_dat = '0;
    corrupt_en = 1'b0;
    corrupt_adr = '0;

    tbl[0] = '{src: 6'd0,  dst: 6'd40, len: 7'd4,   eff: 4,  nexp: 3, exp: {16'h3333, 16'h2222, 16'h1111}};
    tbl[1] = '{src: 6'd62, dst: 6'd2,  len: 7'd3,   eff: 3,  nexp: 3, exp: {16'h1111, 16'hBBBB, 16'hAAAA}};
    tbl[2] = '{src: 6'd5,  dst: 6'd6,  len: 7'd3,   eff: 3,  nexp: 3, exp: {16'h5A5A, 16'h5A5A, 16'h5A5A}};
    tbl[3] = '{src: 6'd20, dst: 6'd30, len: 7'd0,   eff: 0,  nexp: 0, exp: '0};
    tbl[4] = '{src: 6'd0,  dst: 6'd63, len: 7'd1,   eff: 1,  nexp: 1, exp: {16'h0, 16'h0, 16'h1111}};
    tbl[5] = '{src: 6'd10, dst: 6'd20, len: 7'd100, eff: 64, nexp: 0, exp: '0};

    repeat (2) @(negedge clk);
    chk("reset_outputs", out_bits(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", out_bits(), 32'd0);

    for (int k = 0; k < 64; k++) preload(6'(k), 16'(32'hC000 + k));
    preload(6'd0, 16'h1111);
    preload(6'd1, 16'h2222);
    preload(6'd2, 16'h3333);
    preload(6'd3, 16'h4444);
    preload(6'd5, 16'h5A5A);
    preload(6'd62, 16'hAAAA);
    preload(6'd63, 16'hBBBB);

    for (int t = 0; t < 6; t++) begin
      e_before = n_e;
      run_copy(tbl[t].src, tbl[t].dst, tbl[t].len, tbl[t].eff, 1'b0);
      chk("mem_e_cycles", 32'(n_e - e_before), 32'(K * tbl[t].eff));
      for (int k = 0; k < tbl[t].nexp; k++)
        chk("dst_word_const", 32'(ram[6'(32'(tbl[t].dst) + k)]), 32'(tbl[t].exp[k]));
      chk_mem(tbl[t].dst, tbl[t].eff);
    end

    // Reset in the middle of a len=8 copy from 0 to 16.
    preload(6'd0, 16'h1111);
    preload(6'd1, 16'h2222);
    preload(6'd2, 16'h3333);
    preload(6'd3, 16'h4444);
    for (int k = 16; k < 24; k++) preload(6'(k), 16'(32'hD000 + k));
    for (int k = 0; k < 8; k++) sb.push_back('{adr: 6'(16 + k), dat: model[k]});
    bus.start = 1'b1;
    bus.src = 6'd0;
    bus.dst = 6'd16;
    bus.len = 7'd8;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int t = 0; t < 100 && sb.size() > 4; t++) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", out_bits(), 32'd0);
    chk("rst_writes_done", 32'(sb.size()), 32'd4);
    sb.delete();
    chk("rst_word16", 32'(ram[16]), 32'h1111);
    chk("rst_word17", 32'(ram[17]), 32'h2222);
    chk("rst_word18", 32'(ram[18]), 32'h3333);
    chk("rst_word19", 32'(ram[19]), 32'h4444);
    chk("rst_word20", 32'(ram[20]), 32'hD014);
    for (int k = 0; k < 4; k++) model[16 + k] = model[k];
    @(negedge clk);
    chk("rst_held_outputs", out_bits(), 32'd0);
    rst = 1'b0;
    run_copy(6'd0, 6'd30, 7'd2, 2, 1'b0);
    chk_mem(6'd30, 2);

`ifdef RAM64_COPIER_VERIFY_EN
    // Corrupted write to word 41 must raise err; next start clears it.
    corrupt_en = 1'b1;
    corrupt_adr = 6'd41;
    run_copy(6'd0, 6'd40, 7'd4, 4, 1'b1);
    corrupt_en = 1'b0;
    chk("err_sticky_idle", 32'(bus.err), 32'd1);
    run_copy(6'd0, 6'd50, 7'd1, 1, 1'b0);
`endif

    chk("rw_conflict", 32'(n_conflict), 32'd0);
    chk("sb_final", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
